fx_expander: RTL and testbench

Downward expander / noise gate for the stereo FX chain, and the inverse of the compressor stage. A peak envelope follower and a five-state gate machine drive a per-sample gain ramp. Signals below threshold are attenuated toward a ratio-defined floor; signals at or above threshold pass at unity. It sits in the same FX slot interface as the other effects: signed stereo in and out, with 7-bit user parameters.

---
 rtl/fx_expander.sv | 190 +++++++++++++++++++
 tb/tb_fx_expander.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fx_expander.sv
// Stereo downward expander / noise gate: peak envelope follower, five-state gate
// machine and per-sample gain ramp, two pipeline stages from sample_en to out_valid.
`timescale 1ns/1ps
module fx_expander #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned PARAM_W      = 7,
    parameter int unsigned HOLD_SAMPLES = 480,
    parameter int unsigned ENV_DECAY    = 6
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sample_en,
    input  logic [1:0][DATA_W-1:0]      audio_in,
    output logic [1:0][DATA_W-1:0]      audio_out,
    output logic                        out_valid,
    input  logic [PARAM_W-1:0]          threshold,
    input  logic [PARAM_W-1:0]          ratio,
    input  logic [PARAM_W-1:0]          attack,
    input  logic [PARAM_W-1:0]          release_rate,
    output logic                        gate_open
);
    localparam int unsigned MAG_W     = DATA_W - 1;
    localparam int unsigned GAIN_W    = DATA_W;
    localparam int unsigned PROD_W    = DATA_W + GAIN_W + 1;
    localparam int unsigned THR_SHIFT = DATA_W - 1 - PARAM_W;
    localparam int unsigned HOLD_W    = $clog2(HOLD_SAMPLES + 1);
    localparam logic [GAIN_W-1:0]  UNITY     = GAIN_W'(1) << (DATA_W - 1);
    localparam logic [PARAM_W-1:0] P_MAX     = '1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_SAMPLES - 1);

    typedef enum logic [2:0] {
        ST_OPEN,
        ST_HOLD,
        ST_CLOSING,
        ST_CLOSED,
        ST_OPENING
    } state_t;

    state_t              state, state_next;
    logic [GAIN_W-1:0]   g, g_next;
    logic [MAG_W-1:0]    env, env_next;
    logic [HOLD_W-1:0]   hold_cnt, hold_next;
    logic [1:0][DATA_W-1:0] s1_audio;
    logic                s1_valid;

    logic [MAG_W-1:0]    mag_l, mag_r, peak, dec, env_dec, env_new, thr;
    logic                above;
    logic [GAIN_W-1:0]   floor_g, atk_step, rel_step, g_dn, g_rel, g_atk;
    logic [GAIN_W:0]     g_sum;
    state_t              close_state, open_state;
    logic signed [PROD_W-1:0] prod_l, prod_r;
    logic                unused_bits;

    // Absolute value; the most negative code saturates to full scale.
    function automatic logic [MAG_W-1:0] magnitude(input logic [DATA_W-1:0] x);
        logic [DATA_W-1:0] neg;
        neg = ~x + DATA_W'(1);
        if (!x[DATA_W-1])
            return x[MAG_W-1:0];
        else if (x[MAG_W-1:0] == '0)
            return '1;
        else
            return neg[MAG_W-1:0];
    endfunction

    always_comb begin
        mag_l = magnitude(audio_in[0]);
        mag_r = magnitude(audio_in[1]);
        peak  = (mag_l > mag_r) ? mag_l : mag_r;
        dec   = env >> ENV_DECAY;
        if (env != '0 && dec == '0)
            dec = MAG_W'(1);
        env_dec = env - dec;
        env_new = (peak > env_dec) ? peak : env_dec;
        thr     = MAG_W'(threshold) << THR_SHIFT;
        above   = (env_new >= thr);

        floor_g  = (ratio == '0) ? UNITY : (GAIN_W'(P_MAX - ratio) << THR_SHIFT);
        atk_step = UNITY >> attack[PARAM_W-1:PARAM_W-4];
        rel_step = UNITY >> release_rate[PARAM_W-1:PARAM_W-4];

        // Closing rule: saturating step down, never below the floor.
        g_dn        = (g >= rel_step) ? (g - rel_step) : '0;
        g_rel       = (g_dn < floor_g) ? floor_g : g_dn;
        close_state = (g_rel == floor_g) ? ST_CLOSED : ST_CLOSING;

        g_sum      = {1'b0, g} + {1'b0, atk_step};
        g_atk      = (g_sum >= {1'b0, UNITY}) ? UNITY : g_sum[GAIN_W-1:0];
        open_state = (g_atk == UNITY) ? ST_OPEN : ST_OPENING;
    end

    always_comb begin
        state_next = state;
        g_next     = g;
        env_next   = env;
        hold_next  = hold_cnt;
        if (sample_en) begin
            env_next = env_new;
            case (state)
                ST_OPEN: begin
                    g_next = UNITY;
                    if (!above) begin
                        state_next = ST_HOLD;
                        hold_next  = '0;
                    end
                end
                ST_HOLD: begin
                    if (above) begin
                        state_next = ST_OPEN;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state_next = close_state;
                        g_next     = g_rel;
                    end else begin
                        hold_next = hold_cnt + HOLD_W'(1);
                    end
                end
                ST_CLOSING: begin
                    if (above) begin
                        state_next = open_state;
                        g_next     = g_atk;
                    end else begin
                        state_next = close_state;
                        g_next     = g_rel;
                    end
                end
                ST_CLOSED: begin
                    g_next = floor_g;
                    if (above) begin
                        state_next = open_state;
                        g_next     = g_atk;
                    end
                end
                ST_OPENING: begin
                    if (!above) begin
                        state_next = close_state;
                        g_next     = g_rel;
                    end else begin
                        state_next = open_state;
                        g_next     = g_atk;
                    end
                end
                default: state_next = ST_OPEN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= ST_OPEN;
        else
            state <= state_next;
    end

    // Stage 2 multiplies the stage-1 sample by the gain computed from it.
    always_comb begin
        prod_l = $signed(s1_audio[0]) * $signed({1'b0, g});
        prod_r = $signed(s1_audio[1]) * $signed({1'b0, g});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            g         <= UNITY;
            env       <= '0;
            hold_cnt  <= '0;
            gate_open <= 1'b1;
            s1_audio  <= '0;
            s1_valid  <= 1'b0;
            audio_out <= '0;
            out_valid <= 1'b0;
        end else begin
            g         <= g_next;
            env       <= env_next;
            hold_cnt  <= hold_next;
            gate_open <= (state_next == ST_OPEN) || (state_next == ST_HOLD);
            s1_valid  <= sample_en;
            if (sample_en)
                s1_audio <= audio_in;
            out_valid <= s1_valid;
            if (s1_valid) begin
                audio_out[0] <= prod_l[DATA_W+DATA_W-2:DATA_W-1];
                audio_out[1] <= prod_r[DATA_W+DATA_W-2:DATA_W-1];
            end
        end
    end

    assign unused_bits = ^{attack[PARAM_W-5:0], release_rate[PARAM_W-5:0],
                           prod_l[PROD_W-1:DATA_W+DATA_W-1], prod_l[DATA_W-2:0],
                           prod_r[PROD_W-1:DATA_W+DATA_W-1], prod_r[DATA_W-2:0]};

endmodule

// File: tb/tb_fx_expander.sv
// Directed self-checking bench for fx_expander (hold length shortened to 4 samples).
`timescale 1ns/1ps
module tb_fx_expander;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned PARAM_W = 7;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic                   sample_en = 1'b0;
    logic [1:0][DATA_W-1:0] audio_in = '0;
    logic [1:0][DATA_W-1:0] audio_out;
    logic                   out_valid;
    logic [PARAM_W-1:0]     threshold = '0;
    logic [PARAM_W-1:0]     ratio = '0;
    logic [PARAM_W-1:0]     attack = '0;
    logic [PARAM_W-1:0]     release_rate = '0;
    logic                   gate_open;

    int checks = 0;
    int failures = 0;

    fx_expander #(.HOLD_SAMPLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_en    (sample_en),
        .audio_in     (audio_in),
        .audio_out    (audio_out),
        .out_valid    (out_valid),
        .threshold    (threshold),
        .ratio        (ratio),
        .attack       (attack),
        .release_rate (release_rate),
        .gate_open    (gate_open)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sample_en = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic set_in(input int l, input int r);
        audio_in[0] = 16'(l);
        audio_in[1] = 16'(r);
    endtask

    // One isolated strobe: gate state after stage 1, output after stage 2.
    task automatic sample_chk(input string tag, input int l, input int r,
                              input int el, input int er, input logic eg);
        sample_en = 1'b1;
        set_in(l, r);
        @(negedge clk);
        sample_en = 1'b0;
        check({tag, "_gate"}, 32'(gate_open), 32'(eg));
        check({tag, "_vld_early"}, 32'(out_valid), 0);
        @(negedge clk);
        check({tag, "_vld"}, 32'(out_valid), 1);
        check({tag, "_l"}, 32'($signed(audio_out[0])), el);
        check({tag, "_r"}, 32'($signed(audio_out[1])), er);
    endtask

    task automatic close_gate();
        threshold = 7'd16; ratio = 7'd127; release_rate = 7'd0; attack = 7'd0;
        for (int i = 1; i <= 4; i++) sample_chk("close_hold", 100, 100, 100, 100, 1'b1);
        sample_chk("close_shut", 100, 100, 0, 0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_out_l", 32'($signed(audio_out[0])), 0);
        check("rst_out_r", 32'($signed(audio_out[1])), 0);
        check("rst_vld", 32'(out_valid), 0);
        check("rst_gate", 32'(gate_open), 1);

        // Bypass: unity for any threshold, even after the gate closes.
        ratio = 7'd0; threshold = 7'd0;
        for (int i = 0; i < 3; i++) sample_chk("byp_thr0", 1234, -1234, 1234, -1234, 1'b1);
        threshold = 7'd127;
        for (int i = 1; i <= 6; i++) sample_chk("byp_thr127", 1234, -1234, 1234, -1234, i <= 4);

        // Back-to-back strobes at full rate.
        threshold = 7'd0;
        sample_en = 1'b1; set_in(1000, -2000);
        @(negedge clk); set_in(30000, -30000);
        @(negedge clk); set_in(-7, 7);
        check("b2b_a_vld", 32'(out_valid), 1);
        check("b2b_a_l", 32'($signed(audio_out[0])), 1000);
        check("b2b_a_r", 32'($signed(audio_out[1])), -2000);
        @(negedge clk); sample_en = 1'b0;
        check("b2b_b_l", 32'($signed(audio_out[0])), 30000);
        check("b2b_b_r", 32'($signed(audio_out[1])), -30000);
        @(negedge clk);
        check("b2b_c_vld", 32'(out_valid), 1);
        check("b2b_c_l", 32'($signed(audio_out[0])), -7);
        @(negedge clk);
        check("b2b_idle_vld", 32'(out_valid), 0);
        check("b2b_hold_r", 32'($signed(audio_out[1])), 7);

        // Gate close then full opening ramp at step 0x80.
        do_reset();
        close_gate();
        sample_chk("closed", 100, 100, 0, 0, 1'b0);
        attack = 7'h40;
        for (int k = 1; k <= 256; k++) sample_chk("ramp", 8192, 8192, 32 * k, 32 * k, k == 256);
        sample_chk("ramp_open", 8192, 8192, 8192, 8192, 1'b1);

        // Ramp to g=0x4000, negative-one rounding, then reversal into CLOSING.
        do_reset();
        close_gate();
        attack = 7'h40;
        for (int k = 1; k <= 127; k++) sample_chk("ramp2", 8192, 8192, 32 * k, 32 * k, 1'b0);
        sample_chk("neg_one", -1, -1, -1, -1, 1'b0);
        release_rate = 7'h40; threshold = 7'd127;
        sample_chk("reverse1", 8192, -8192, 4064, -4064, 1'b0);
        sample_chk("reverse2", 8192, -8192, 4032, -4032, 1'b0);

        // Most negative input: peak saturates to full scale and stays above threshold.
        do_reset();
        threshold = 7'd127; ratio = 7'd127; release_rate = 7'd0; attack = 7'd0;
        for (int i = 0; i < 3; i++) sample_chk("minneg_l", -32768, 0, -32768, 0, 1'b1);
        for (int i = 0; i < 3; i++) sample_chk("minneg_r", 0, -32768, 0, -32768, 1'b1);

        // Reset while CLOSING with a sample in flight.
        do_reset();
        threshold = 7'd16; ratio = 7'd127; release_rate = 7'h40; attack = 7'd0;
        for (int i = 0; i < 4; i++) sample_chk("mid_hold", 100, 100, 100, 100, 1'b1);
        sample_chk("mid_closing", 100, 100, 99, 99, 1'b0);
        sample_en = 1'b1; set_in(500, 500);
        @(negedge clk); sample_en = 1'b0; reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("flush_vld", 32'(out_valid), 0);
        check("flush_out", 32'($signed(audio_out[0])), 0);
        check("flush_gate", 32'(gate_open), 1);
        @(negedge clk);
        check("flush_vld2", 32'(out_valid), 0);
        sample_chk("after_rst", 100, 100, 100, 100, 1'b1);

        // Reset and sample_en together: reset wins.
        reset = 1'b1; sample_en = 1'b1; set_in(500, 500);
        @(negedge clk); reset = 1'b0; sample_en = 1'b0;
        check("rst_se_vld", 32'(out_valid), 0);
        check("rst_se_gate", 32'(gate_open), 1);
        @(negedge clk);
        check("rst_se_vld2", 32'(out_valid), 0);
        check("rst_se_out", 32'($signed(audio_out[0])), 0);
        sample_chk("rst_se_next", 100, 100, 100, 100, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
